// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL bit positions and default base address
// shared by the timer_cmp block and its prescaler.
package timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

    // Byte offsets from the base of the register window.
    localparam logic [31:0] TIME_LO    = 32'h00;
    localparam logic [31:0] TIME_HI    = 32'h04;
    localparam logic [31:0] CTRL       = 32'h08;
    localparam logic [31:0] PRESCALE   = 32'h0C;
    localparam logic [31:0] STATUS     = 32'h10;
    localparam logic [31:0] CMP_BASE   = 32'h20;
    localparam int          CMP_STRIDE = 8;

    // CTRL bit positions.
    localparam int EN_BIT = 0;
    localparam int IE_LSB = 8;

    // Register selected by a decoded offset.
    typedef enum logic [2:0] {
        REG_TIME_LO,
        REG_TIME_HI,
        REG_CTRL,
        REG_PRESCALE,
        REG_STATUS,
        REG_RSVD,
        REG_CMP_LO,
        REG_CMP_HI
    } reg_sel_e;

    // Offset of the last word in the window (CMP_HI of the last channel).
    function automatic logic [31:0] window_last(input int n_cmp);
        return 32'h1C + 32'(CMP_STRIDE * n_cmp);
    endfunction

endpackage

// File: rtl/timer_cmp_if.sv
// timer_cmp_if: core data-bus signals of one MMIO peripheral slot.
// dout is shared and tri-stated by every slave outside its own window.
interface timer_cmp_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output we, addr, din, input dout);
    modport slave  (input we, addr, din, output dout);
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides clk by (div_i + 1) while enabled, producing a
// one-cycle tick each time the counter reaches div_i.
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic [PRESCALE_W-1:0] div_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pc_q, pc_d;

    assign tick_o = en_i && (pc_q == div_i);

    // Next counter value: clear wins, wrap on tick, hold while disabled.
    always_comb begin
        // NOTE: default first so every path assigns pc_d and no latch is inferred.
        pc_d = pc_q;
        if (clear_i) begin
            pc_d = '0;
        end else if (tick_o) begin
            pc_d = '0;
        end else if (en_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!rstn) pc_q <= '0;
        else       pc_q <= pc_d;
    end

endmodule

// File: rtl/timer_cmp.sv
// timer_cmp: MMIO 64-bit timer with prescaler and N_CMP sticky compare
// interrupts. Define TIMER_SNAPSHOT_EN to latch time[63:32] into a shadow
// register on every TIME_LO read, making LO-then-HI read pairs tear-free.
module timer_cmp
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          N_CMP      = 2,
    parameter int          PRESCALE_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    timer_cmp_if.slave       bus,
    output logic [N_CMP-1:0] irq
);

    localparam logic [31:0] LAST_OFF = window_last(N_CMP);
    localparam int          IDX_W    = (N_CMP > 1) ? $clog2(N_CMP) : 1;

    logic [31:0]           off;
    logic                  hit, wr, tick, pc_clear;
    reg_sel_e              sel;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           rdata;

    logic [63:0]           time_q, time_d;
    logic                  en_q, en_d;
    logic [N_CMP-1:0]      ie_q, ie_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [N_CMP-1:0]      pending_q, pending_d;
    logic [63:0]           cmp_q [N_CMP];
    logic [63:0]           cmp_d [N_CMP];
`ifdef TIMER_SNAPSHOT_EN
    logic [31:0]           shadow_hi_q;
`endif

    // addr >= BASE_ADDR guards the wrap of the subtraction for low addresses.
    assign off = bus.addr - BASE_ADDR;
    assign hit = (bus.addr[1:0] == 2'b00) && (bus.addr >= BASE_ADDR) && (off <= LAST_OFF);
    assign wr  = bus.we && hit;

    // Offset decode into a register select and compare channel index.
    always_comb begin
        sel = REG_RSVD;
        idx = '0;
        if (off >= CMP_BASE) begin
            sel = off[2] ? REG_CMP_HI : REG_CMP_LO;
            idx = IDX_W'((off - CMP_BASE) >> 3);
        end else begin
            case (off)
                TIME_LO:  sel = REG_TIME_LO;
                TIME_HI:  sel = REG_TIME_HI;
                CTRL:     sel = REG_CTRL;
                PRESCALE: sel = REG_PRESCALE;
                STATUS:   sel = REG_STATUS;
                default:  sel = REG_RSVD;
            endcase
        end
    end

    // Any TIME or PRESCALE write restarts the divide period.
    assign pc_clear = wr && (sel == REG_TIME_LO || sel == REG_TIME_HI || sel == REG_PRESCALE);

    timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk     (clk),
        .rstn    (rstn),
        .en_i    (en_q),
        .clear_i (pc_clear),
        .div_i   (prescale_q),
        .tick_o  (tick)
    );

    // Next-state for time, control, compare values and pending flags.
    always_comb begin
        time_d     = time_q;
        en_d       = en_q;
        ie_d       = ie_q;
        prescale_d = prescale_q;
        cmp_d      = cmp_q;
        pending_d  = pending_q;

        // A half-write suppresses the increment entirely, so no carry leaks.
        if (wr && sel == REG_TIME_LO)      time_d[31:0]  = bus.din;
        else if (wr && sel == REG_TIME_HI) time_d[63:32] = bus.din;
        else if (tick)                     time_d        = time_q + 64'd1;

        if (wr && sel == REG_CTRL) begin
            en_d = bus.din[EN_BIT];
            ie_d = bus.din[IE_LSB +: N_CMP];
        end
        if (wr && sel == REG_PRESCALE) prescale_d = bus.din[PRESCALE_W-1:0];
        if (wr && sel == REG_CMP_LO)   cmp_d[idx][31:0]  = bus.din;
        if (wr && sel == REG_CMP_HI)   cmp_d[idx][63:32] = bus.din;

        // W1C first, then a compare hit sets, so set wins over clear.
        if (wr && sel == REG_STATUS) pending_d = pending_q & ~bus.din[N_CMP-1:0];
        for (int i = 0; i < N_CMP; i++) begin
            if (time_q >= cmp_q[i]) pending_d[i] = 1'b1;
        end
    end

    // Register file update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            time_q     <= '0;
            en_q       <= 1'b1;
            ie_q       <= '0;
            prescale_q <= '0;
            pending_q  <= '0;
            // NOTE: cmp_q is a small flop array, not a RAM, so each entry is reset.
            for (int i = 0; i < N_CMP; i++) cmp_q[i] <= '1;
`ifdef TIMER_SNAPSHOT_EN
            shadow_hi_q <= '0;
`endif
        end else begin
            time_q     <= time_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            prescale_q <= prescale_d;
            pending_q  <= pending_d;
            for (int i = 0; i < N_CMP; i++) cmp_q[i] <= cmp_d[i];
`ifdef TIMER_SNAPSHOT_EN
            if (hit && !bus.we && sel == REG_TIME_LO) shadow_hi_q <= time_q[63:32];
`endif
        end
    end

    // Combinational read mux; reserved offsets and unused bits read 0.
    always_comb begin
        rdata = '0;
        case (sel)
            REG_TIME_LO:  rdata = time_q[31:0];
`ifdef TIMER_SNAPSHOT_EN
            REG_TIME_HI:  rdata = shadow_hi_q;
`else
            REG_TIME_HI:  rdata = time_q[63:32];
`endif
            REG_CTRL: begin
                rdata[EN_BIT]          = en_q;
                rdata[IE_LSB +: N_CMP] = ie_q;
            end
            REG_PRESCALE: rdata = 32'(prescale_q);
            REG_STATUS:   rdata[N_CMP-1:0] = pending_q;
            REG_CMP_LO:   rdata = cmp_q[idx][31:0];
            REG_CMP_HI:   rdata = cmp_q[idx][63:32];
            default:      rdata = '0;
        endcase
    end

    assign bus.dout = hit ? rdata : 32'hzzzz_zzzz;
    assign irq      = pending_q & ie_q;

endmodule
